// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if;
    logic       im_stall;
    logic       dm_stall;
    logic       ex_pc_src;
    logic       ex_mem_r;
    logic [4:0] ex_rd_addr;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       pc_hold;
    logic       pc_redirect;
    logic [1:0] sf_if_id;
    logic [1:0] sf_id_ex;
    logic [1:0] sf_ex_mem;
    logic [1:0] sf_mem_wb;
    logic       mem_timeout;

    modport master (
        output im_stall, dm_stall, ex_pc_src, ex_mem_r, ex_rd_addr,
        output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
        input  pc_hold, pc_redirect, sf_if_id, sf_id_ex, sf_ex_mem, sf_mem_wb,
        input  mem_timeout
    );

    modport slave (
        input  im_stall, dm_stall, ex_pc_src, ex_mem_r, ex_rd_addr,
        input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
        output pc_hold, pc_redirect, sf_if_id, sf_id_ex, sf_ex_mem, sf_mem_wb,
        output mem_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: sf[0]=flush, sf[1]=hold.
// Defining HAZARD_PERF_EN adds the stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned WdW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0] TimeoutVal = WdW'(TIMEOUT);

    // A zero-width counter is not a legal configuration.
    if (CNT_W == 0) begin : g_cnt_w_chk
        $error("CNT_W must be nonzero");
    end

    typedef enum logic {StRun, StKill} state_e;

    state_e         state_q, state_d;
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           mem_timeout_q, mem_timeout_d;
    logic           timeout_hit;
    logic           load_use;
    logic           busy;
    logic           pc_hold_c, pc_redirect_c;
    logic [1:0]     sf_if_id_c, sf_id_ex_c, sf_ex_mem_c, sf_mem_wb_c;

    assign busy     = hz.im_stall | hz.dm_stall;
    assign load_use = hz.ex_mem_r && (hz.ex_rd_addr != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                       (hz.id_use_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));

    always_comb begin
        state_d       = state_q;
        pc_hold_c     = 1'b0;
        pc_redirect_c = 1'b0;
        sf_if_id_c    = 2'b00;
        sf_id_ex_c    = 2'b00;
        sf_ex_mem_c   = 2'b00;
        sf_mem_wb_c   = 2'b00;
        if (state_q == StKill) begin
            // Wrong-path fetch in flight: squash whatever it returns.
            pc_hold_c  = 1'b1;
            sf_if_id_c = 2'b01;
            if (hz.dm_stall) begin
                sf_id_ex_c  = 2'b10;
                sf_ex_mem_c = 2'b10;
                sf_mem_wb_c = 2'b01;
            end
            if (!hz.im_stall) state_d = StRun;
        end else if (hz.dm_stall) begin
            pc_hold_c   = 1'b1;
            sf_if_id_c  = 2'b10;
            sf_id_ex_c  = 2'b10;
            sf_ex_mem_c = 2'b10;
            sf_mem_wb_c = 2'b01;
        end else if (hz.ex_pc_src) begin
            pc_redirect_c = 1'b1;
            sf_if_id_c    = 2'b01;
            sf_id_ex_c    = 2'b01;
            if (hz.im_stall) state_d = StKill;
        end else if (load_use) begin
            pc_hold_c  = 1'b1;
            sf_if_id_c = 2'b10;
            sf_id_ex_c = 2'b01;
        end else if (hz.im_stall) begin
            pc_hold_c  = 1'b1;
            sf_if_id_c = 2'b01;
        end
    end

    // Watchdog counts the current busy cycle, so the flag rises within that cycle.
    always_comb begin
        wd_cnt_d = '0;
        if ((TIMEOUT != 0) && busy) begin
            wd_cnt_d = (wd_cnt_q == TimeoutVal) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        timeout_hit   = (TIMEOUT != 0) && (wd_cnt_d == TimeoutVal);
        mem_timeout_d = mem_timeout_q | timeout_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            wd_cnt_q      <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_cnt_q      <= wd_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Outputs are forced low for the whole time reset is asserted.
    assign hz.pc_hold     = rst & pc_hold_c;
    assign hz.pc_redirect = rst & pc_redirect_c;
    assign hz.sf_if_id    = {2{rst}} & sf_if_id_c;
    assign hz.sf_id_ex    = {2{rst}} & sf_id_ex_c;
    assign hz.sf_ex_mem   = {2{rst}} & sf_ex_mem_c;
    assign hz.sf_mem_wb   = {2{rst}} & sf_mem_wb_c;
    assign hz.mem_timeout = rst & (mem_timeout_q | timeout_hit);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_hold_c && !(&stall_cnt_q))              stall_cnt_d = stall_cnt_q + 1'b1;
        if ((sf_id_ex_c == 2'b01) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences,
// checked through an expected-value queue.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    // {pc_hold, pc_redirect, if_id, id_ex, ex_mem, mem_wb, mem_timeout}
    localparam logic [10:0] EIdle   = 11'b0;
    localparam logic [10:0] ELoad   = {1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] EDm     = {1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 2'b01, 1'b0};
    localparam logic [10:0] EBr     = {1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] EIm     = {1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] EKillDm = {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b01, 1'b0};
    localparam logic [10:0] ETo     = 11'b1;

    typedef struct {
        string      name;
        logic       im, dm, br, ld;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2;
        logic [10:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [10:0] exp_q[$];

    pipe_hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .TIMEOUT(8),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation time limit");
    end

    function automatic vec_t mk(string nm, logic im, logic dm, logic br, logic ld,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic [10:0] exp);
        vec_t v;
        v.name = nm; v.im = im; v.dm = dm; v.br = br; v.ld = ld;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exp = exp;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {hz.pc_hold, hz.pc_redirect, hz.sf_if_id, hz.sf_id_ex, hz.sf_ex_mem,
                hz.sf_mem_wb, hz.mem_timeout};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.im_stall    = v.im;
        hz.dm_stall    = v.dm;
        hz.ex_pc_src   = v.br;
        hz.ex_mem_r    = v.ld;
        hz.ex_rd_addr  = v.rd;
        hz.id_rs1_addr = v.rs1;
        hz.id_rs2_addr = v.rs2;
        hz.id_use_rs1  = v.u1;
        hz.id_use_rs2  = v.u2;
    endtask

    // One clock: drive after the edge, record expectation, compare at the falling edge.
    task automatic step(input vec_t v);
        logic [10:0] want;
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s got=empty_queue want=entry", v.name);
        end else begin
            want = exp_q.pop_front();
            check(v.name, 64'(outs()), 64'(want));
        end
    endtask

    vec_t tbl[$];

    initial begin
        total = 0;
        bad   = 0;
        tbl.push_back(mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));
        tbl.push_back(mk("load_use_rs1",   0, 0, 0, 1, 5, 5, 0, 1, 0, ELoad));
        tbl.push_back(mk("load_rd0",       0, 0, 0, 1, 0, 0, 0, 1, 0, EIdle));
        tbl.push_back(mk("load_no_use",    0, 0, 0, 1, 5, 5, 0, 0, 0, EIdle));
        tbl.push_back(mk("load_use_rs2",   0, 0, 0, 1, 7, 1, 7, 1, 1, ELoad));
        tbl.push_back(mk("no_load",        0, 0, 0, 0, 5, 5, 0, 1, 0, EIdle));
        tbl.push_back(mk("dm_stall",       0, 1, 0, 0, 0, 0, 0, 0, 0, EDm));
        tbl.push_back(mk("dm_over_branch", 0, 1, 1, 0, 0, 0, 0, 0, 0, EDm));
        tbl.push_back(mk("branch",         0, 0, 1, 0, 0, 0, 0, 0, 0, EBr));
        tbl.push_back(mk("im_stall",       1, 0, 0, 0, 0, 0, 0, 0, 0, EIm));
        tbl.push_back(mk("load_over_im",   1, 0, 0, 1, 9, 9, 0, 1, 0, ELoad));
        tbl.push_back(mk("dm_over_all",    1, 1, 0, 1, 9, 9, 0, 1, 0, EDm));
        tbl.push_back(mk("branch_over_ld", 0, 0, 1, 1, 9, 9, 0, 1, 0, EBr));
        tbl.push_back(mk("idle2",          0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));

        rst = 1'b0;
        drive(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));
        repeat (2) @(posedge clk);
        #1;
        hz.ex_mem_r = 1'b1; hz.ex_rd_addr = 5'd5; hz.id_rs1_addr = 5'd5;
        hz.id_use_rs1 = 1'b1; hz.dm_stall = 1'b1;
        #1;
        check("reset_outputs", 64'(outs()), 64'(EIdle));
        drive(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));
        @(negedge clk);
        rst = 1'b1;

`ifdef HAZARD_PERF_EN
        @(posedge clk);
        #1;
        check("perf_stall_init", 64'(stall_cnt), 64'd0);
        check("perf_flush_init", 64'(flush_cnt), 64'd0);
        step(mk("perf_load1", 0, 0, 0, 1, 5, 5, 0, 1, 0, ELoad));
        step(mk("perf_load2", 0, 0, 0, 1, 5, 5, 0, 1, 0, ELoad));
        step(mk("perf_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));
        check("perf_stall_two", 64'(stall_cnt), 64'd2);
        check("perf_flush_two", 64'(flush_cnt), 64'd2);
`endif

        foreach (tbl[i]) step(tbl[i]);

        // Branch held behind a data-memory stall, then released.
        for (int i = 0; i < 3; i++) step(mk("br_dm_wait", 0, 1, 1, 0, 0, 0, 0, 0, 0, EDm));
        step(mk("br_dm_release", 0, 0, 1, 0, 0, 0, 0, 0, 0, EBr));
        step(mk("br_dm_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));

        // Redirect while a fetch is outstanding: the fetch returns 4 cycles later.
        step(mk("kill_enter",   1, 0, 1, 0, 0, 0, 0, 0, 0, EBr));
        step(mk("kill_ign_br",  1, 0, 1, 0, 0, 0, 0, 0, 0, EIm));
        step(mk("kill_dm",      1, 1, 1, 0, 0, 0, 0, 0, 0, EKillDm));
        step(mk("kill_wait",    1, 0, 0, 0, 0, 0, 0, 0, 0, EIm));
        step(mk("kill_im_fall", 0, 0, 0, 1, 5, 5, 0, 1, 0, EIm));
        step(mk("kill_back_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));

        // Reset asserted while in KILL.
        step(mk("rk_enter", 1, 0, 1, 0, 0, 0, 0, 0, 0, EBr));
        step(mk("rk_in_kill", 1, 0, 0, 0, 0, 0, 0, 0, 0, EIm));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rk_outputs_zero", 64'(outs()), 64'(EIdle));
        @(negedge clk);
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));
        #1;
        rst = 1'b1;
        step(mk("rk_run_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));
        step(mk("rk_run_im",   1, 0, 0, 0, 0, 0, 0, 0, 0, EIm));
        step(mk("rk_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, EIdle));

        // Watchdog with TIMEOUT=8: flag rises on the 8th busy cycle and sticks.
        for (int i = 0; i < 10; i++) begin
            step(mk($sformatf("wd_busy%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 0,
                    (i >= 7) ? (EIm | ETo) : EIm));
        end
        for (int i = 0; i < 3; i++) step(mk("wd_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, ETo));

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
